// File: rtl/whirlpool_nonce_scanner.sv
// rtl/whirlpool_nonce_scanner.sv - nonce sequencer wrapped around the whirlpool round core
//
// Takes one unit of work (midstate, block template, target, inclusive nonce range),
// feeds each nonce to the core, waits for hash_ready, and reports hits and completion.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   work_valid / work_ready  work handshake (ready only in IDLE, low during rst)
//   work_state/block/target  work payload, latched on accept
//   nonce_start, nonce_end   inclusive nonce range, latched on accept
//   abort                    abandon the current work (no done, no found)
//   core_rst                 restart pulse to the core (also high during rst)
//   core_state, core_block   held core inputs; core_block = {template[511:32], nonce}
//   core_hash, core_hash_ready  core result, hash valid only in the ready cycle
//   found_valid              one-cycle hit pulse
//   found_nonce, found_hash_hi  nonce and top 64 hash bits of the last hit
//   done                     one-cycle pulse when the range ends or stop-on-found fires
//   hash_count               hashes completed for the current work, cleared on accept

module whirlpool_nonce_scanner #(
    parameter bit STOP_ON_FOUND = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [511:0] work_state,
    input  logic [511:0] work_block,
    input  logic [63:0]  work_target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic         abort,
    output logic         core_rst,
    output logic [511:0] core_state,
    output logic [511:0] core_block,
    input  logic [511:0] core_hash,
    input  logic         core_hash_ready,
    output logic         found_valid,
    output logic [31:0]  found_nonce,
    output logic [63:0]  found_hash_hi,
    output logic         done,
    output logic [31:0]  hash_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state;
    logic [511:0]  mid_q;
    logic [479:0]  tmpl_q;
    logic [31:0]   nonce_q;
    logic [31:0]   end_q;
    logic [63:0]   target_q;

    logic          hit;
    logic          last_nonce;

    // The nonce field of the template and the low hash bits are never consumed;
    // fold them into a sink so the intent is explicit.
    logic          unused_bits;
    assign unused_bits = ^{work_block[31:0], core_hash[447:0]};

    assign hit        = (core_hash[511:448] <= target_q);
    assign last_nonce = (nonce_q == end_q);

    assign work_ready = (state == IDLE) && !rst;
    // Holding the core in reset while we are in reset keeps it from running on
    // stale inputs.
    assign core_rst   = rst || (state == ISSUE);
    assign core_state = mid_q;
    assign core_block = {tmpl_q, nonce_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mid_q         <= '0;
            tmpl_q        <= '0;
            nonce_q       <= '0;
            end_q         <= '0;
            target_q      <= '0;
            found_valid   <= 1'b0;
            found_nonce   <= '0;
            found_hash_hi <= '0;
            done          <= 1'b0;
            hash_count    <= '0;
        end else begin
            found_valid <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (work_valid) begin
                        mid_q      <= work_state;
                        tmpl_q     <= work_block[511:32];
                        target_q   <= work_target;
                        nonce_q    <= nonce_start;
                        end_q      <= nonce_end;
                        hash_count <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= abort ? IDLE : WAIT;
                end
                WAIT: begin
                    // abort wins over a simultaneous result: nothing is reported.
                    if (abort) begin
                        state <= IDLE;
                    end else if (core_hash_ready) begin
                        hash_count <= hash_count + 32'd1;
                        if (hit) begin
                            found_valid   <= 1'b1;
                            found_nonce   <= nonce_q;
                            found_hash_hi <= core_hash[511:448];
                        end
                        // Termination is by equality with end_q only, so a start
                        // just past the end walks the full 2^32 wrap.
                        if (last_nonce || (STOP_ON_FOUND && hit)) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            nonce_q <= nonce_q + 32'd1;
                            state   <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_whirlpool_nonce_scanner.sv
// tb/tb_whirlpool_nonce_scanner.sv - self-checking bench for whirlpool_nonce_scanner

module tb_whirlpool_nonce_scanner;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] work_state = '0;
    logic [511:0] work_block = '0;
    logic [63:0]  work_target = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;

    // index 0: STOP_ON_FOUND=0, index 1: STOP_ON_FOUND=1
    logic         wv [2];
    logic         ab [2];
    logic         wr [2];
    logic         crst [2];
    logic [511:0] cstate [2];
    logic [511:0] cblock [2];
    logic [511:0] chash [2];
    logic         rdy [2];
    logic         chr [2];
    logic         fv [2];
    logic [31:0]  fn [2];
    logic [63:0]  fh [2];
    logic         dn [2];
    logic [31:0]  hc [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        whirlpool_nonce_scanner #(.STOP_ON_FOUND(g == 1)) u_dut (
            .clk             (clk),
            .rst             (rst),
            .work_valid      (wv[g]),
            .work_ready      (wr[g]),
            .work_state      (work_state),
            .work_block      (work_block),
            .work_target     (work_target),
            .nonce_start     (nonce_start),
            .nonce_end       (nonce_end),
            .abort           (ab[g]),
            .core_rst        (crst[g]),
            .core_state      (cstate[g]),
            .core_block      (cblock[g]),
            .core_hash       (chash[g]),
            .core_hash_ready (rdy[g]),
            .found_valid     (fv[g]),
            .found_nonce     (fn[g]),
            .found_hash_hi   (fh[g]),
            .done            (dn[g]),
            .hash_count      (hc[g])
        );
    end

    // Core model: latency lat after the restart pulse, top hash bits chosen per nonce.
    int           lat = 1;
    logic [31:0]  hit_n = '0;
    logic [63:0]  hit_hi = '0;
    logic [63:0]  miss_hi = '0;
    logic         stray = 1'b0;
    int           cnt [2];
    logic [511:0] cap_blk [2];
    logic [511:0] cap_st [2];
    logic [63:0]  top_v [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rdy[i]   = chr[i] | stray;
            top_v[i] = (cblock[i][31:0] == hit_n) ? hit_hi : miss_hi;
            // Outside the ready cycle the top bits are inverted garbage.
            chash[i] = rdy[i] ? {top_v[i], cblock[i][447:0] ^ cstate[i][447:0]}
                              : {~top_v[i], cblock[i][447:0] ^ cstate[i][447:0]};
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                cnt[i] <= 0;
                chr[i] <= 1'b0;
            end else if (crst[i]) begin
                cnt[i]     <= lat;
                chr[i]     <= 1'b0;
                cap_blk[i] <= cblock[i];
                cap_st[i]  <= cstate[i];
            end else if (cnt[i] != 0) begin
                cnt[i] <= cnt[i] - 1;
                chr[i] <= (cnt[i] == 1);
            end else begin
                chr[i] <= 1'b0;
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor
    int          fcnt [2];
    int          dcnt [2];
    int          crst_cyc [2];
    int          cur_sel = 0;
    logic [31:0] seen [$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (crst[i]) crst_cyc[i]++;
            if (fv[i]) fcnt[i]++;
            if (dn[i]) dcnt[i]++;
            if (chr[i]) begin
                chk($sformatf("d%0d_inputs_stable", i),
                    {63'd0, (cblock[i] === cap_blk[i]) && (cstate[i] === cap_st[i])}, 64'd1);
                if (i == cur_sel) seen.push_back(cblock[i][31:0]);
            end
        end
    end

    task automatic clr_mon();
        for (int i = 0; i < 2; i++) begin
            fcnt[i] = 0;
            dcnt[i] = 0;
            crst_cyc[i] = 0;
        end
        seen.delete();
    endtask

    typedef struct {
        int          sel;
        logic [31:0] ns;
        logic [31:0] ne;
        logic [63:0] tgt;
        logic [31:0] hn;
        logic [63:0] hhi;
        logic [63:0] mhi;
        int          lat;
        int          exp_hc;
        int          exp_nf;
        logic [31:0] exp_fn;
        logic [63:0] exp_fh;
        logic        exp_dwf;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v, input int idx);
        int s;
        logic got;
        s = v.sel;
        #1;
        cur_sel     = s;
        hit_n       = v.hn;
        hit_hi      = v.hhi;
        miss_hi     = v.mhi;
        lat         = v.lat;
        work_target = v.tgt;
        nonce_start = v.ns;
        nonce_end   = v.ne;
        work_block  = {16{$urandom()}};
        work_state  = {16{$urandom()}};
        clr_mon();
        @(negedge clk);
        chk($sformatf("v%0d_ready_before", idx), {63'd0, wr[s]}, 64'd1);
        wv[s] = 1'b1;
        @(posedge clk);
        #1 wv[s] = 1'b0;
        chk($sformatf("v%0d_issue_after_accept", idx), {63'd0, crst[s]}, 64'd1);
        got = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (dn[s]) begin
                got = 1'b1;
                break;
            end
        end
        chk($sformatf("v%0d_done_seen", idx), {63'd0, got}, 64'd1);
        chk($sformatf("v%0d_ready_with_done", idx), {63'd0, wr[s]}, 64'd1);
        chk($sformatf("v%0d_found_with_done", idx), {63'd0, fv[s]}, {63'd0, v.exp_dwf});
        repeat (2) @(negedge clk);
        #1;
        chk($sformatf("v%0d_hash_count", idx), {32'd0, hc[s]}, 64'(v.exp_hc));
        chk($sformatf("v%0d_found_pulses", idx), 64'(fcnt[s]), 64'(v.exp_nf));
        chk($sformatf("v%0d_done_pulses", idx), 64'(dcnt[s]), 64'd1);
        chk($sformatf("v%0d_core_rst_pulses", idx), 64'(crst_cyc[s]), 64'(v.exp_hc));
        chk($sformatf("v%0d_found_nonce", idx), {32'd0, fn[s]}, {32'd0, v.exp_fn});
        chk($sformatf("v%0d_found_hash_hi", idx), fh[s], v.exp_fh);
        chk($sformatf("v%0d_nonces_seen", idx), 64'(seen.size()), 64'(v.exp_hc));
        for (int k = 0; k < seen.size(); k++) begin
            chk($sformatf("v%0d_nonce_seq%0d", idx, k), {32'd0, seen[k]}, {32'd0, v.ns + 32'(k)});
        end
    endtask

    initial begin
        logic [511:0] old_st;
        logic got;
        for (int i = 0; i < 2; i++) begin
            wv[i] = 1'b0;
            ab[i] = 1'b0;
        end

        //            sel ns            ne            tgt                    hn     hit_hi                 miss_hi                lat hc nf fn     fh                     dwf
        vecs[0] = '{0, 32'h0,        32'h0,        64'h0,                 32'h0, 64'h1,                 64'h1,                 3, 1, 0, 32'h0, 64'h0,                 1'b0};
        vecs[1] = '{0, 32'hFFFFFFFE, 32'h00000001, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 2, 4, 4, 32'h1, 64'h0123_4567_89AB_CDEF, 1'b1};
        vecs[2] = '{0, 32'd5,        32'd9,        64'h0000_1000_0000_0000, 32'd7, 64'h0000_1000_0000_0000, 64'h0000_1000_0000_0001, 1, 5, 1, 32'd7, 64'h0000_1000_0000_0000, 1'b0};
        vecs[3] = '{1, 32'd5,        32'd9,        64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1, 1, 32'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[4] = '{1, 32'd5,        32'd9,        64'd100,               32'd7, 64'd100,               64'd101,               4, 3, 1, 32'd7, 64'd100,               1'b1};
        vecs[5] = '{0, 32'd42,       32'd42,       64'h8000_0000_0000_0000, 32'h0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1, 1, 0, 32'd7, 64'h0000_1000_0000_0000, 1'b0};
        vecs[6] = '{0, 32'd3,        32'd5,        64'h10,                32'd5, 64'h10,                64'h11,                2, 3, 1, 32'd5, 64'h10,                1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_d%0d_work_ready", i), {63'd0, wr[i]}, 64'd0);
            chk($sformatf("rst_d%0d_core_rst", i), {63'd0, crst[i]}, 64'd1);
            chk($sformatf("rst_d%0d_outputs_zero", i),
                {63'd0, (fv[i] | dn[i]) == 1'b0 && fn[i] == 0 && fh[i] == 0 && hc[i] == 0
                        && cblock[i] == 0 && cstate[i] == 0}, 64'd1);
        end
        rst = 1'b0;
        #1;
        chk("rst_release_work_ready", {63'd0, wr[0]}, 64'd1);

        for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

        // Abort in the same cycle as a hitting hash_ready; work_valid held through WAIT.
        #1;
        cur_sel = 0; lat = 3; hit_n = 0; hit_hi = 64'h0; miss_hi = 64'h0;
        work_target = 64'hFFFF_FFFF_FFFF_FFFF; nonce_start = 32'd0; nonce_end = 32'd9;
        work_state = {16{32'hA5A5_0001}};
        old_st = work_state;
        clr_mon();
        @(negedge clk);
        wv[0] = 1'b1;
        @(posedge clk);
        #1 work_state = ~old_st;
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (chr[0]) begin
                got = 1'b1;
                break;
            end
        end
        chk("abort_ready_seen", {63'd0, got}, 64'd1);
        chk("abort_state_not_relatched", {63'd0, cstate[0] == old_st}, 64'd1);
        ab[0] = 1'b1;
        wv[0] = 1'b0;
        @(posedge clk);
        #1 ab[0] = 1'b0;
        @(negedge clk);
        chk("abort_idle_next", {63'd0, wr[0]}, 64'd1);
        chk("abort_no_found", {63'd0, fv[0]}, 64'd0);
        chk("abort_no_done", {63'd0, dn[0]}, 64'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("abort_found_pulses", 64'(fcnt[0]), 64'd0);
        chk("abort_done_pulses", 64'(dcnt[0]), 64'd0);
        chk("abort_single_issue", 64'(crst_cyc[0]), 64'd1);

        // rst pulsed in WAIT
        lat = 5; hit_n = 0; hit_hi = 64'd5; miss_hi = 64'd5;
        work_target = 64'd0; nonce_start = 32'd100; nonce_end = 32'd200;
        work_block = {16{32'h1234_5678}};
        clr_mon();
        @(negedge clk);
        wv[0] = 1'b1;
        @(posedge clk);
        #1 wv[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstw_core_block", {63'd0, cblock[0] == {work_block[511:32], 32'd100}}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rstw_core_rst", {63'd0, crst[0]}, 64'd1);
        chk("rstw_not_ready", {63'd0, wr[0]}, 64'd0);
        @(negedge clk);
        chk("rstw_outputs_zero",
            {63'd0, (fv[0] | dn[0]) == 1'b0 && fn[0] == 0 && fh[0] == 0 && hc[0] == 0
                    && cblock[0] == 0 && cstate[0] == 0}, 64'd1);
        rst = 1'b0;
        #1;
        chk("rstw_ready_after", {63'd0, wr[0]}, 64'd1);
        repeat (10) @(negedge clk);
        #1;
        chk("rstw_no_done", 64'(dcnt[0]), 64'd0);

        // Stray hash_ready in IDLE is ignored
        @(negedge clk);
        stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        @(negedge clk);
        chk("stray_no_found", {63'd0, fv[0]}, 64'd0);
        chk("stray_no_done", {63'd0, dn[0]}, 64'd0);
        chk("stray_hash_count", {32'd0, hc[0]}, 64'd0);
        chk("stray_still_idle", {63'd0, wr[0]}, 64'd1);

        // New work after reset
        run_vec(vecs[2], 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
